// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: port bundle for the multi-port register file.
//   master : decode / write-back side (drives ids, write ports, issue)
//   slave  : register file (drives read data, busy flags, special views)
// Signals:
//   A_id, B_id            read-port register ids
//   w0_en/w0_id/w0_data   ALU write-back port
//   w1_en/w1_id/w1_data   load write-back port
//   iss_en/iss_id         mark an id as having a pending producer
//   A_data/B_data         read data
//   A_busy/B_busy         read id has a pending producer
//   busy_any              OR of every busy bit
//   T/SP/IH/RA_data       stored special-register values
interface reg_file_mp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int ID_W = ADDR_W + 1;

  logic [ID_W-1:0]   A_id;
  logic [ID_W-1:0]   B_id;
  logic              w0_en;
  logic [ID_W-1:0]   w0_id;
  logic [DATA_W-1:0] w0_data;
  logic              w1_en;
  logic [ID_W-1:0]   w1_id;
  logic [DATA_W-1:0] w1_data;
  logic              iss_en;
  logic [ID_W-1:0]   iss_id;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;
  logic              A_busy;
  logic              B_busy;
  logic              busy_any;
  logic [DATA_W-1:0] T_data;
  logic [DATA_W-1:0] SP_data;
  logic [DATA_W-1:0] IH_data;
  logic [DATA_W-1:0] RA_data;

  modport master (
    output A_id, B_id, w0_en, w0_id, w0_data, w1_en, w1_id, w1_data,
           iss_en, iss_id,
    input  A_data, B_data, A_busy, B_busy, busy_any,
           T_data, SP_data, IH_data, RA_data
  );

  modport slave (
    input  A_id, B_id, w0_en, w0_id, w0_data, w1_en, w1_id, w1_data,
           iss_en, iss_id,
    output A_data, B_data, A_busy, B_busy, busy_any,
           T_data, SP_data, IH_data, RA_data
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with pending-write scoreboard.
// Holds 2^ADDR_W GPRs plus T, SP, IH, RA (ids 2^ADDR_W .. 2^ADDR_W+3) and
// one busy bit per register. Two combinational read ports, two write-back
// ports (w1 has priority over w0), one issue port that sets busy.
// State changes on the falling edge of clk_50MHz; rst is asynchronous,
// active-low and clears all data and busy bits.
// Ports:
//   clk_50MHz  system clock (falling-edge active)
//   rst        asynchronous active-low reset
//   bus        reg_file_mp_if.slave (ids, write ports, issue, read outputs)
// Build option:
//   REG_FILE_BYPASS_EN  forward same-cycle write data to the read ports.
//                       Undefined (default): reads show stored state only.
module reg_file_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic         clk_50MHz,
  input  logic         rst,
  reg_file_mp_if.slave bus
);
  localparam int ID_W  = ADDR_W + 1;
  localparam int N_GPR = 1 << ADDR_W;
  localparam int N_REG = N_GPR + 4;

  logic [DATA_W-1:0] regs [N_REG];
  logic [N_REG-1:0]  busy;

  logic [N_REG-1:0]  w0_hit;
  logic [N_REG-1:0]  w1_hit;
  logic [N_REG-1:0]  iss_hit;

  logic [ID_W-1:0]   rd_id   [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return int'(id) < N_REG;
  endfunction

  // One-hot decode; ids beyond the map match no register and are dropped.
  always_comb begin
    w0_hit  = '0;
    w1_hit  = '0;
    iss_hit = '0;
    for (int i = 0; i < N_REG; i++) begin
      w0_hit[i]  = bus.w0_en  && (int'(bus.w0_id)  == i);
      w1_hit[i]  = bus.w1_en  && (int'(bus.w1_id)  == i);
      iss_hit[i] = bus.iss_en && (int'(bus.iss_id) == i);
    end
  end

  // Storage update at falling edge
  always_ff @(negedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REG; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        if (w1_hit[i]) begin
          regs[i] <= bus.w1_data;
        end else if (w0_hit[i]) begin
          regs[i] <= bus.w0_data;
        end
        // A same-cycle issue belongs to a newer producer, so it beats the clear.
        if (iss_hit[i]) begin
          busy[i] <= 1'b1;
        end else if (w0_hit[i] || w1_hit[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign rd_id[0] = bus.A_id;
  assign rd_id[1] = bus.B_id;

  // Read ports: stored state, optionally overridden by in-flight writes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (id_ok(rd_id[p])) begin
        rd_data[p] = regs[rd_id[p]];
        rd_busy[p] = busy[rd_id[p]];
`ifdef REG_FILE_BYPASS_EN
        if (w0_hit[rd_id[p]]) begin
          rd_data[p] = bus.w0_data;
          rd_busy[p] = 1'b0;
        end
        if (w1_hit[rd_id[p]]) begin
          rd_data[p] = bus.w1_data;
          rd_busy[p] = 1'b0;
        end
        if ((w0_hit[rd_id[p]] || w1_hit[rd_id[p]]) && iss_hit[rd_id[p]]) begin
          rd_busy[p] = 1'b1;
        end
`endif
      end
    end
  end

  assign bus.A_data   = rd_data[0];
  assign bus.A_busy   = rd_busy[0];
  assign bus.B_data   = rd_data[1];
  assign bus.B_busy   = rd_busy[1];
  assign bus.busy_any = |busy;

  // Special views always reflect storage, never the bypass path.
  assign bus.T_data  = regs[N_GPR + 0];
  assign bus.SP_data = regs[N_GPR + 1];
  assign bus.IH_data = regs[N_GPR + 2];
  assign bus.RA_data = regs[N_GPR + 3];
endmodule
